// File: rtl/rd_req_arbiter_if.sv
// Handshake bundle between the requester blocks, the round-robin
// arbiter and the shared read-cycle engine.
//   master : arbiter side (drives grants, go, done/err, busy)
//   slave  : requester/engine side (drives req and ds)
interface rd_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) ();
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  sel;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] err;
  logic            go;
  logic            ds;
  logic            busy;

  modport master (
    input  req, ds,
    output gnt, sel, done, err, go, busy
  );

  modport slave (
    output req, ds,
    input  gnt, sel, done, err, go, busy
  );
endinterface

// File: rtl/rd_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one read-cycle engine among NREQ
// requesters. A grant issues one go pulse, waits for ds, then pulses
// done to the granted requester. The just-served requester becomes
// lowest priority.
// Optional watchdog: define RD_ARB_WATCHDOG_EN to abort a WAIT that lasts
// WDOG_CYCLES cycles without ds; the requester then gets err instead of done.
module rd_req_arbiter #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int WDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  rd_req_arbiter_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    GO   = 4'b0010,
    WAIT = 4'b0100,
    DONE = 4'b1000
  } state_t;

  state_t          state_reg, state_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] done_reg, done_next;
  logic [NREQ-1:0] err_reg, err_next;
  logic [IDW-1:0]  sel_reg, sel_next;
  logic [IDW-1:0]  ptr_reg, ptr_next;
  logic            go_reg, go_next;
  logic            busy_reg, busy_next;
  logic [IDW-1:0]  scan_idx;
  logic [IDW-1:0]  pick;
  logic            found;
  logic            timeout;

  // Parameter sanity check at elaboration
  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || WDOG_CYCLES < 1) begin : g_bad_params
    $error("rd_req_arbiter: NREQ/IDW/WDOG_CYCLES out of range");
  end

  // Round-robin pick: first set req bit scanning upward from ptr+1 with wrap
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      scan_idx = IDW'((int'(ptr_reg) + i) % NREQ);
      if (!found && bus.req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

`ifdef RD_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);

  logic [WDW-1:0] wdog_reg, wdog_next;

  // Watchdog count: zero outside WAIT, +1 per WAIT cycle
  always_comb begin
    wdog_next = '0;
    if (state_reg == WAIT) begin
      wdog_next = wdog_reg + 1'b1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_reg <= '0;
    end else begin
      wdog_reg <= wdog_next;
    end
  end

  // Limit is reached at the end of this WAIT cycle; a same-cycle ds wins
  assign timeout = (state_reg == WAIT) && !bus.ds &&
                   (wdog_reg == WDW'(WDOG_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next state plus outputs decoded from the next state
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    done_next  = '0;
    err_next   = '0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next     = GO;
          gnt_next       = '0;
          gnt_next[pick] = 1'b1;
          sel_next       = pick;
        end
      end
      GO: begin
        state_next = WAIT;
      end
      WAIT: begin
        // ds matters only here; stray strobes elsewhere are dropped
        if (bus.ds || timeout) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        gnt_next   = '0;
        ptr_next   = sel_reg;
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
    go_next   = (state_next == GO);
    busy_next = (state_next != IDLE);
    if (state_next == DONE) begin
      if (timeout) begin
        err_next = gnt_reg;
      end else begin
        done_next = gnt_reg;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      sel_reg   <= '0;
      ptr_reg   <= IDW'(NREQ - 1);
      done_reg  <= '0;
      err_reg   <= '0;
      go_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      go_reg    <= go_next;
      busy_reg  <= busy_next;
    end
  end

  assign bus.gnt  = gnt_reg;
  assign bus.sel  = sel_reg;
  assign bus.done = done_reg;
  assign bus.err  = err_reg;
  assign bus.go   = go_reg;
  assign bus.busy = busy_reg;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Directed bench for rd_req_arbiter: a vector table (reset, single
// requester, stray ds, round-robin, early release) plus hand-written
// sequences for asynchronous reset mid-transaction and the WAIT watchdog
// (RD_ARB_WATCHDOG_EN selects which watchdog sequence is built).
module tb_rd_req_arbiter;

  logic clk;
  logic rst_n;

  rd_req_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

  rd_req_arbiter #(.NREQ(4), .IDW(2), .WDOG_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ds;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [3:0] done;
    logic       go;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  function automatic void add(input logic rst, input logic [3:0] req, input logic ds,
                              input logic [3:0] gnt, input logic [1:0] sel,
                              input logic [3:0] done, input logic go, input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.ds = ds; v.gnt = gnt; v.sel = sel;
    v.done = done; v.go = go; v.busy = busy;
    vecs.push_back(v);
  endfunction

  // Compare all outputs; sel is meaningful only while a grant is expected
  task automatic check_outputs(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                               input logic [3:0] e_done, input logic [3:0] e_err,
                               input logic e_go, input logic e_busy);
    n_vec++;
    if (bus.gnt !== e_gnt) begin
      n_bad++; $display("FAIL %s gnt got %b want %b", tag, bus.gnt, e_gnt);
    end
    if (e_gnt != 4'b0000 && bus.sel !== e_sel) begin
      n_bad++; $display("FAIL %s sel got %0d want %0d", tag, bus.sel, e_sel);
    end
    if (bus.done !== e_done) begin
      n_bad++; $display("FAIL %s done got %b want %b", tag, bus.done, e_done);
    end
    if (bus.err !== e_err) begin
      n_bad++; $display("FAIL %s err got %b want %b", tag, bus.err, e_err);
    end
    if (bus.go !== e_go) begin
      n_bad++; $display("FAIL %s go got %b want %b", tag, bus.go, e_go);
    end
    if (bus.busy !== e_busy) begin
      n_bad++; $display("FAIL %s busy got %b want %b", tag, bus.busy, e_busy);
    end
    $display("%s: req=%b ds=%b gnt=%b sel=%0d go=%b done=%b err=%b busy=%b",
             tag, bus.req, bus.ds, bus.gnt, bus.sel, bus.go, bus.done, bus.err, bus.busy);
  endtask

  // One cycle with reset held, then release at a falling edge
  task automatic do_reset();
    rst_n = 1'b0; bus.req = 4'b0000; bus.ds = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single grant to req[0], then a long WAIT; ds optionally on WAIT cycle last_w
  task automatic wdog_seq(input string tag, input int n_wait, input bit ds_last);
    do_reset();
    bus.req = 4'b0001; bus.ds = 1'b0;
    @(negedge clk);
    check_outputs({tag, "_go"}, 4'b0001, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b1);
    bus.req = 4'b0000;
    @(negedge clk);
    for (int w = 1; w <= n_wait; w++) begin
      check_outputs($sformatf("%s_wait%0d", tag, w), 4'b0001, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b1);
      bus.ds = (ds_last && w == n_wait) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    bus.ds = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.ds = 1'b0;

    // Reset with random activity, release, stray ds in IDLE
    add(1, 4'($urandom), 1'($urandom), 4'b0000, 2'd0, 4'b0000, 0, 0);
    add(1, 4'($urandom), 1'($urandom), 4'b0000, 2'd0, 4'b0000, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 2'd0, 4'b0000, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 2'd0, 4'b0000, 0, 0);
    // Single requester 2, ds 3 cycles after go
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 4'b0000, 1, 1);
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 4'b0000, 0, 1);
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 4'b0000, 0, 1);
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 4'b0000, 0, 1);
    add(0, 4'b0100, 1, 4'b0100, 2'd2, 4'b0100, 0, 1);
    add(0, 4'b0100, 0, 4'b0000, 2'd0, 4'b0000, 0, 0);
    // Back-to-back regrant of 2; stray ds during GO is ignored
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 4'b0000, 1, 1);
    add(0, 4'b0100, 1, 4'b0100, 2'd2, 4'b0000, 0, 1);
    add(0, 4'b0000, 0, 4'b0100, 2'd2, 4'b0000, 0, 1);
    add(0, 4'b0000, 1, 4'b0100, 2'd2, 4'b0100, 0, 1);
    add(0, 4'b0000, 0, 4'b0000, 2'd0, 4'b0000, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 2'd0, 4'b0000, 0, 0);
    // Round robin from reset: all requesting, grant order 0,1,2,3,0
    add(1, 4'b1111, 1, 4'b0000, 2'd0, 4'b0000, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 2'd0, 4'b0000, 0, 0);
    for (int t = 0; t < 5; t++) begin
      logic [3:0] g;
      logic [1:0] s;
      g = 4'b0001 << (t % 4);
      s = 2'(t % 4);
      add(0, 4'b1111, 0, g, s, 4'b0000, 1, 1);
      add(0, 4'b1111, 0, g, s, 4'b0000, 0, 1);
      add(0, 4'b1111, 0, g, s, 4'b0000, 0, 1);
      add(0, 4'b1111, 1, g, s, g, 0, 1);
      add(0, 4'b1111, 0, 4'b0000, 2'd0, 4'b0000, 0, 0);
    end
    // ptr now 0: req 1001 grants 3; req dropped in WAIT, done still pulses
    add(0, 4'b1001, 0, 4'b1000, 2'd3, 4'b0000, 1, 1);
    add(0, 4'b1001, 0, 4'b1000, 2'd3, 4'b0000, 0, 1);
    add(0, 4'b0000, 0, 4'b1000, 2'd3, 4'b0000, 0, 1);
    add(0, 4'b0000, 1, 4'b1000, 2'd3, 4'b1000, 0, 1);
    add(0, 4'b0000, 0, 4'b0000, 2'd0, 4'b0000, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      rst_n   = ~vecs[i].rst;
      bus.req = vecs[i].req;
      bus.ds  = vecs[i].ds;
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].done,
                    4'b0000, vecs[i].go, vecs[i].busy);
    end

    // Asynchronous reset during WAIT with gnt=1000 clears outputs at once
    bus.req = 4'b1000; bus.ds = 1'b0;
    @(negedge clk);
    check_outputs("mrst_go", 4'b1000, 2'd3, 4'b0000, 4'b0000, 1'b1, 1'b1);
    bus.req = 4'b0000;
    @(negedge clk);
    check_outputs("mrst_wait", 4'b1000, 2'd3, 4'b0000, 4'b0000, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_outputs("mrst_async", 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; bus.req = 4'b1001;
    @(negedge clk);
    check_outputs("mrst_regrant", 4'b0001, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b1);
    bus.req = 4'b0000;
    @(negedge clk);
    bus.ds = 1'b1;
    @(negedge clk);
    check_outputs("mrst_done", 4'b0001, 2'd0, 4'b0001, 4'b0000, 1'b0, 1'b1);
    bus.ds = 1'b0;

`ifdef RD_ARB_WATCHDOG_EN
    // No ds: err after the 8th WAIT cycle, done stays 0
    wdog_seq("wd_to", 8, 1'b0);
    check_outputs("wd_to_err", 4'b0001, 2'd0, 4'b0000, 4'b0001, 1'b0, 1'b1);
    @(negedge clk);
    check_outputs("wd_to_idle", 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    // ds on the 8th WAIT cycle wins over the limit
    wdog_seq("wd_ds", 8, 1'b1);
    check_outputs("wd_ds_done", 4'b0001, 2'd0, 4'b0001, 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    check_outputs("wd_ds_idle", 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0);
`else
    // Without the watchdog WAIT lasts until ds, however long
    wdog_seq("nowd", 20, 1'b1);
    check_outputs("nowd_done", 4'b0001, 2'd0, 4'b0001, 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    check_outputs("nowd_idle", 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
